// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared types and constants for the iterative multiply/divide
//                unit. This covers the operation encoding, the control FSM
//                states and the iteration count.
//                Optional feature macro: MULDIV_SIGNED_EN, which enables
//                signed MULT/DIV in mult_div_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } muldiv_state_t;

    localparam int MULDIV_ITERS = 32;
    localparam int MULDIV_CNT_W = 6;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/mult_div_unit_iter_core.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_iter_core
//  Description : Combinational single-step datapath. It performs one
//                shift-add multiply step or one restoring-divide step on the
//                {acc_hi, acc_lo} accumulator pair.
//  Ports       : i_is_div  - 1: restoring divide step, 0: shift-add step
//                i_opnd    - multiplicand (multiply) or divisor (divide)
//                i_acc_hi  - partial product upper half / partial remainder
//                i_acc_lo  - remaining multiplier bits / dividend+quotient
//                o_acc_hi  - updated upper accumulator
//                o_acc_lo  - updated lower accumulator
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter_core (
    input  logic        i_is_div,
    input  logic [31:0] i_opnd,
    input  logic [31:0] i_acc_hi,
    input  logic [31:0] i_acc_lo,
    output logic [31:0] o_acc_hi,
    output logic [31:0] o_acc_lo
);

    logic [32:0] w_sum;
    logic [32:0] w_shifted;
    logic [32:0] w_diff;
    logic        w_fits;

    always_comb begin
        // Multiply: add the multiplicand when the current multiplier bit is
        // set, then shift the 65-bit {carry, hi, lo} right by one.
        w_sum     = {1'b0, i_acc_hi} + (i_acc_lo[0] ? {1'b0, i_opnd} : 33'd0);
        // Divide: bring the next dividend bit into the partial remainder and
        // try to subtract the divisor.
        w_shifted = {i_acc_hi, i_acc_lo[31]};
        w_diff    = w_shifted - {1'b0, i_opnd};
        w_fits    = (w_shifted >= {1'b0, i_opnd});

        if (i_is_div) begin
            // The remainder stays below the divisor, so it fits in 32 bits.
            // A zero divisor always fits, which yields an all-ones quotient
            // and leaves the dividend as the remainder.
            o_acc_hi = w_fits ? w_diff[31:0] : w_shifted[31:0];
            o_acc_lo = {i_acc_lo[30:0], w_fits};
        end else begin
            o_acc_hi = w_sum[32:1];
            o_acc_lo = {w_sum[0], i_acc_lo[31:1]};
        end
    end

endmodule : muldiv_iter_core
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : A 32-iteration multiply/divide unit with HI/LO registers.
//                It takes a fixed 33 cycles from start to the result.
//                Optional feature macro: MULDIV_SIGNED_EN. When it is
//                defined, MULT and DIV are signed. When it is undefined, they
//                behave as MULTU and DIVU.
//  Ports       : clk, reset  - clock, synchronous active-high reset
//                start, op   - launch request and operation code
//                a, b        - rs / rt operands
//                mthi, mtlo, wdata - direct HI/LO writes (idle only)
//                busy, done  - in-flight flag, one-cycle result pulse
//                hi, lo      - HI/LO architectural registers
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [MULDIV_CNT_W-1:0] C_LAST_ITER = MULDIV_CNT_W'(MULDIV_ITERS - 1);

    muldiv_state_t          state_q, state_d;
    logic [MULDIV_CNT_W-1:0] cnt_q, cnt_d;
    logic                   is_div_q, is_div_d;
    logic [31:0]            opnd_q, opnd_d;
    logic [31:0]            acc_hi_q, acc_hi_d;
    logic [31:0]            acc_lo_q, acc_lo_d;
    logic [31:0]            hi_q, hi_d;
    logic [31:0]            lo_q, lo_d;
    logic                   done_q, done_d;
`ifdef MULDIV_SIGNED_EN
    logic                   neg_res_q, neg_res_d;
    logic                   neg_rem_q, neg_rem_d;
    logic                   div0_q, div0_d;
`endif

    muldiv_op_t  w_op;
    logic        w_is_div;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_step_hi;
    logic [31:0] w_step_lo;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_op     = muldiv_op_t'(op);
    assign w_is_div = (w_op == DIV) || (w_op == DIVU);

    muldiv_iter_core u_iter_core (
        .i_is_div (is_div_q),
        .i_opnd   (opnd_q),
        .i_acc_hi (acc_hi_q),
        .i_acc_lo (acc_lo_q),
        .o_acc_hi (w_step_hi),
        .o_acc_lo (w_step_lo)
    );

    // Operand magnitudes: the iterations always run unsigned.
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        w_neg_a = ((w_op == MULT) || (w_op == DIV)) && a[31];
        w_neg_b = ((w_op == MULT) || (w_op == DIV)) && b[31];
`else
        w_neg_a = 1'b0;
        w_neg_b = 1'b0;
`endif
        w_mag_a = w_neg_a ? (32'd0 - a) : a;
        w_mag_b = w_neg_b ? (32'd0 - b) : b;
    end

    // Final result shaping (sign correction when signed support is built in).
    always_comb begin
        w_prod = {acc_hi_q, acc_lo_q};
        w_quo  = acc_lo_q;
        w_rem  = acc_hi_q;
`ifdef MULDIV_SIGNED_EN
        if (neg_res_q) begin
            w_prod = 64'd0 - w_prod;
            w_quo  = 32'd0 - w_quo;
        end
        if (neg_rem_q) begin
            w_rem = 32'd0 - w_rem;
        end
        // A zero divisor reports an all-ones quotient regardless of sign.
        if (div0_q) begin
            w_quo = 32'hFFFF_FFFF;
        end
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            opnd_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            opnd_q    <= opnd_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
`ifdef MULDIV_SIGNED_EN
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == C_LAST_ITER) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output logic
    always_comb begin
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        opnd_d    = opnd_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
`ifdef MULDIV_SIGNED_EN
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
`endif
        case (state_q)
            IDLE: begin
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
                if (start) begin
                    cnt_d     = '0;
                    is_div_d  = w_is_div;
                    acc_hi_d  = '0;
                    // Multiply: multiplicand stays put, multiplier shifts out
                    // of acc_lo. Divide: divisor stays put, dividend shifts out.
                    opnd_d    = w_is_div ? w_mag_b : w_mag_a;
                    acc_lo_d  = w_is_div ? w_mag_a : w_mag_b;
`ifdef MULDIV_SIGNED_EN
                    neg_res_d = w_neg_a ^ w_neg_b;
                    neg_rem_d = w_is_div & w_neg_a;
                    div0_d    = w_is_div & (b == 32'd0);
`endif
                end
            end
            RUN: begin
                acc_hi_d = w_step_hi;
                acc_lo_d = w_step_lo;
                cnt_d    = (cnt_q == C_LAST_ITER) ? '0 : cnt_q + 1'b1;
            end
            DONE: begin
                hi_d   = is_div_q ? w_rem : w_prod[63:32];
                lo_d   = is_div_q ? w_quo : w_prod[31:0];
                done_d = 1'b1;
                cnt_d  = '0;
            end
            default: ;
        endcase
    end

    assign busy = (state_q == RUN) || (state_q == DONE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule : mult_div_unit
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Self-checking bench for mult_div_unit. Directed and random
//                operations are compared against an arithmetic reference
//                model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: {hi, lo} straight from integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] f_op, input logic [31:0] fa,
                                              input logic [31:0] fb);
        logic        sgn;
        longint      sa, sb, q, r;
        logic [63:0] res;
        sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
        sgn = ~f_op[0];
`endif
        sa = sgn ? longint'($signed(fa)) : longint'({32'd0, fa});
        sb = sgn ? longint'($signed(fb)) : longint'({32'd0, fb});
        if (!f_op[1]) begin
            res = 64'(sa * sb);
        end else if (fb == 32'd0) begin
            res = {fa, 32'hFFFF_FFFF};
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    // Launch one operation and follow it cycle by cycle to the result.
    // disturb: a second start plus mthi=0xAA arrive while busy.
    // mws: mthi rides along with start in the same cycle.
    task automatic run_op(input string tag, input logic [1:0] t_op, input logic [31:0] ta,
                          input logic [31:0] tb, input bit disturb, input bit mws,
                          input logic [31:0] wd);
        logic [63:0] expv;
        bit          busy_ok, hold_ok, quiet_ok;
        expv  = ref_model(t_op, ta, tb);
        start = 1'b1;
        op    = t_op;
        a     = ta;
        b     = tb;
        if (mws) begin
            mthi  = 1'b1;
            wdata = wd;
        end
        @(posedge clk); #1;
        start = 1'b0;
        mthi  = 1'b0;
        if (mws) exp_hi = wd;
        busy_ok  = 1'b1;
        hold_ok  = 1'b1;
        quiet_ok = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done !== 1'b0) quiet_ok = 1'b0;
            if (hi !== exp_hi || lo !== exp_lo) hold_ok = 1'b0;
            if (disturb && k == 5) begin
                start = 1'b1;
                op    = 2'b11;
                a     = $urandom;
                b     = $urandom;
                mthi  = 1'b1;
                wdata = 32'hAA;
            end else if (disturb && k == 6) begin
                start = 1'b0;
                mthi  = 1'b0;
            end
            @(posedge clk); #1;
        end
        check({tag, "_busy_window"}, 64'(busy_ok), 64'd1);
        check({tag, "_no_early_done"}, 64'(quiet_ok), 64'd1);
        check({tag, "_hilo_hold_busy"}, 64'(hold_ok), 64'd1);
        check({tag, "_done_at_33"}, {62'd0, done, busy}, 64'b10);
        check({tag, "_result"}, {hi, lo}, expv);
        exp_hi = expv[63:32];
        exp_lo = expv[31:0];
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
        check({tag, "_result_hold"}, {hi, lo}, {exp_hi, exp_lo});
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [5];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit no_done;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);
        exp_hi = '0;
        exp_lo = '0;

        // Idle mtlo write
        mtlo  = 1'b1;
        wdata = 32'h1234;
        @(posedge clk); #1;
        mtlo = 1'b0;
        exp_lo = 32'h1234;
        check("mtlo_idle", {hi, lo}, {exp_hi, exp_lo});

        run_op("multu_10x2", 2'b01, 32'd10, 32'd2, 1'b0, 1'b0, 32'd0);
        check("multu_10x2_const", {hi, lo}, 64'h0000_0000_0000_0014);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("divu_10_2", 2'b11, 32'd10, 32'd2, 1'b0, 1'b0, 32'd0);
        check("divu_10_2_const", {hi, lo}, 64'h0000_0000_0000_0005);
        run_op("divu_7_0", 2'b11, 32'd7, 32'd0, 1'b0, 1'b0, 32'd0);
        check("divu_7_0_const", {hi, lo}, 64'h0000_0007_FFFF_FFFF);

        run_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, 32'd0);
`ifdef MULDIV_SIGNED_EN
        check("mult_m3x5_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
`endif
        run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0);
`ifdef MULDIV_SIGNED_EN
        check("div_m7_2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
`endif
        run_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        run_op("mult_min_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'd0);
        run_op("div_m9_0", 2'b10, 32'hFFFF_FFF7, 32'd0, 1'b0, 1'b0, 32'd0);

        // Start and mthi while busy are ignored.
        run_op("busy_ignore", 2'b01, 32'd123456, 32'd789, 1'b1, 1'b0, 32'd0);
        // mthi together with start: written first, then overwritten.
        run_op("mthi_with_start", 2'b11, 32'd100, 32'd7, 1'b0, 1'b1, 32'hCAFE_F00D);

        // Reset in the middle of RUN, also colliding with start/mthi/mtlo.
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd55;
        b     = 32'd66;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("busy_before_reset", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        start = 1'b1;
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'h5555_5555;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        check("reset_midrun", {30'd0, busy, done, hi, lo}, 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        no_done = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
            @(posedge clk); #1;
        end
        check("no_done_after_reset", 64'(no_done), 64'd1);

        for (int i = 0; i < 24; i++) begin
            run_op("random", 2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
                   1'b0, 1'b0, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mult_div_unit
`default_nettype wire
